booth_product_accumulator: RTL and testbench

Downstream consumer of the 8x8 signed Booth multiplier. It takes the 16-bit signed product stream over a valid/ready handshake and sums the products of one frame into a wide accumulator. When the frame's last product is accepted, it presents the sum, sample count and overflow flag on a held output handshake. It sits between the multiplier and the dot-product/FIR result logic.

---
 rtl/booth_product_accumulator.sv | 129 ++++++++++++
 tb/tb_booth_product_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Sums the signed 16-bit products of one frame into a signed ACC_W-bit
// accumulator. When the frame's last product is accepted, the sum, the
// saturating sample count and a sticky overflow flag are presented on a held
// valid/ready output.
// Optional feature: define BOOTH_ACC_SAT_EN to make the accumulator clamp on
// overflow. Without it, the accumulator wraps modulo 2^ACC_W.
module booth_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic                    r_ovf;
  logic signed [ACC_W-1:0] r_out_sum;
  logic        [CNT_W-1:0] r_out_count;
  logic                    r_out_ovf;

  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_acc_next;
  logic        [CNT_W-1:0] w_cnt_next;
  logic                    w_ovf_next;

  // Map the one-bit-wider sum back onto the accumulator width: clamp toward
  // the sign of the true sum when saturation is built in, otherwise wrap.
  function automatic logic signed [ACC_W-1:0] fn_resolve(input logic signed [ACC_W:0] s);
`ifdef BOOTH_ACC_SAT_EN
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) fn_resolve = {1'b1, {(ACC_W-1){1'b0}}};
      else          fn_resolve = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      fn_resolve = s[ACC_W-1:0];
    end
`else
    fn_resolve = s[ACC_W-1:0];
`endif
  endfunction

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] fn_cnt_inc(input logic [CNT_W-1:0] c);
    if (&c) fn_cnt_inc = c;
    else    fn_cnt_inc = c + CNT_W'(1);
  endfunction

  // Next-state arithmetic for an accepted beat, one guard bit wider than
  // the accumulator so the overflow can be seen in the top two bits.
  always_comb begin
    w_sum      = {r_acc[ACC_W-1], r_acc} +
                 {{(ACC_W-15){in_product[15]}}, in_product};
    w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    w_acc_next = fn_resolve(w_sum);
    w_cnt_next = fn_cnt_inc(r_cnt);
    w_ovf_next = r_ovf | w_ovf;
  end

  // Frame FSM: accumulate in ACCUM, present and hold the result in HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (in_last) begin
              r_out_sum   <= w_acc_next;
              r_out_count <= w_cnt_next;
              r_out_ovf   <= w_ovf_next;
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= S_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator. Two instances share one stimulus
// stream: A uses the default widths (24/8), B uses ACC_W=17, CNT_W=2 so the
// overflow and count-saturation corners are reachable. A reference model
// tracks the arithmetic frame sum of each instance.
module tb_booth_product_accumulator;

  localparam int AW_A = 24, CW_A = 8;
  localparam int AW_B = 17, CW_B = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_product = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic            a_in_ready, a_out_valid, a_ovf;
  logic [AW_A-1:0] a_sum;
  logic [CW_A-1:0] a_cnt;
  logic            b_in_ready, b_out_valid, b_ovf;
  logic [AW_B-1:0] b_sum;
  logic [CW_B-1:0] b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // model state: index 0 = instance A, 1 = instance B
  longint m_acc [2];
  longint m_cnt [2];
  bit     m_ovf [2];

  always #5 clock = ~clock;

  booth_product_accumulator #(.ACC_W(AW_A), .CNT_W(CW_A)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_sum), .out_count(a_cnt), .out_ovf(a_ovf));

  booth_product_accumulator #(.ACC_W(AW_B), .CNT_W(CW_B)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_sum), .out_count(b_cnt), .out_ovf(b_ovf));

  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  // Add one product to the frame as plain integer arithmetic, then bring
  // the running value back into the signed W-bit range the way the build does.
  function automatic void model_step(input int k, input longint p);
    int     w;
    int     cw;
    longint lim;
    longint s;
    w   = (k == 0) ? AW_A : AW_B;
    cw  = (k == 0) ? CW_A : CW_B;
    lim = longint'(1) << (w - 1);
    s   = m_acc[k] + p;
    if (s > lim - 1 || s < -lim) begin
      m_ovf[k] = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
      s = (s > 0) ? lim - 1 : -lim;
`else
      s = (s + lim) % (2 * lim);
      if (s < 0) s = s + 2 * lim;
      s = s - lim;
`endif
    end
    m_acc[k] = s;
    if (m_cnt[k] < (longint'(1) << cw) - 1) m_cnt[k] = m_cnt[k] + 1;
  endfunction

  task automatic check_results(input string tag);
    chk({tag, "_sumA"}, longint'($signed(a_sum)), m_acc[0]);
    chk({tag, "_cntA"}, longint'(a_cnt), m_cnt[0]);
    chk({tag, "_ovfA"}, longint'(a_ovf), longint'(m_ovf[0]));
    chk({tag, "_sumB"}, longint'($signed(b_sum)), m_acc[1]);
    chk({tag, "_cntB"}, longint'(b_cnt), m_cnt[1]);
    chk({tag, "_ovfB"}, longint'(b_ovf), longint'(m_ovf[1]));
  endtask

  // Called at a falling edge while both instances are in ACCUM.
  task automatic do_beat(input logic [15:0] p, input logic last);
    chk("rdyA", longint'(a_in_ready), 1);
    chk("rdyB", longint'(b_in_ready), 1);
    chk("vldA_pre", longint'(a_out_valid), 0);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    @(posedge clock);
    model_step(0, longint'($signed(p)));
    model_step(1, longint'($signed(p)));
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b0;
      in_last    = 1'($urandom_range(0, 1));
      in_product = 16'($urandom);
      @(negedge clock);
    end
    in_last = 1'b0;
  endtask

  // Called at the falling edge right after the last beat was accepted.
  task automatic finish_frame(input string tag, input int hold);
    chk({tag, "_vldA"}, longint'(a_out_valid), 1);
    chk({tag, "_vldB"}, longint'(b_out_valid), 1);
    check_results(tag);
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'b1;
      in_product = 16'h1234;
      in_last    = 1'($urandom_range(0, 1));
      out_ready  = 1'b0;
      @(negedge clock);
      chk({tag, "_hold_rdyA"}, longint'(a_in_ready), 0);
      chk({tag, "_hold_vldB"}, longint'(b_out_valid), 1);
      chk({tag, "_hold_sumA"}, longint'($signed(a_sum)), m_acc[0]);
      chk({tag, "_hold_sumB"}, longint'($signed(b_sum)), m_acc[1]);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    model_clear();
    chk({tag, "_rel_vldA"}, longint'(a_out_valid), 0);
    chk({tag, "_rel_rdyA"}, longint'(a_in_ready), 1);
    chk({tag, "_rel_rdyB"}, longint'(b_in_ready), 1);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset_n  = 1'b0;
    #2;
    chk("rst_rdyA", longint'(a_in_ready), 1);
    chk("rst_vldA", longint'(a_out_valid), 0);
    chk("rst_sumA", longint'(a_sum), 0);
    chk("rst_cntA", longint'(a_cnt), 0);
    chk("rst_ovfA", longint'(a_ovf), 0);
    chk("rst_rdyB", longint'(b_in_ready), 1);
    chk("rst_vldB", longint'(b_out_valid), 0);
    chk("rst_sumB", longint'(b_sum), 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] p;
    int          len;
    model_clear();
    @(negedge clock);
    apply_reset();

    // 3-beat frame 100, -50, 25
    do_beat(16'd100, 1'b0);
    do_beat(16'hFFCE, 1'b0);
    do_beat(16'd25, 1'b1);
    chk("t1_sum_const", longint'($signed(a_sum)), 75);
    chk("t1_cnt_const", longint'(a_cnt), 3);
    finish_frame("t1", 5);

    // next frame starts from zero after the held result
    do_beat(16'd9, 1'b1);
    chk("t2_sum_const", longint'($signed(a_sum)), 9);
    finish_frame("t2", 0);

    // overflow at ACC_W=17
    do_beat(16'h7FFF, 1'b0);
    do_beat(16'h7FFF, 1'b0);
    do_beat(16'h0002, 1'b1);
`ifdef BOOTH_ACC_SAT_EN
    chk("t3_sumB_const", longint'($signed(b_sum)), 65535);
`else
    chk("t3_sumB_const", longint'($signed(b_sum)), -65536);
`endif
    chk("t3_ovfB_const", longint'(b_ovf), 1);
    chk("t3_ovfA_const", longint'(a_ovf), 0);
    finish_frame("t3", 1);

    // single-beat frame with most negative product
    do_beat(16'h8000, 1'b1);
    chk("t4_sumA_const", longint'(a_sum), longint'(24'hFF8000));
    finish_frame("t4", 0);

    // reset mid-frame discards the partial sum
    do_beat(16'd300, 1'b0);
    do_beat(16'd400, 1'b0);
    apply_reset();
    do_beat(16'd7, 1'b1);
    chk("t5_sum_const", longint'($signed(a_sum)), 7);
    chk("t5_cnt_const", longint'(a_cnt), 1);
    finish_frame("t5", 0);

    // count saturation at CNT_W=2
    for (int i = 0; i < 5; i++) do_beat(16'd1, 1'(i == 4));
    chk("t6_cntB_const", longint'(b_cnt), 3);
    chk("t6_sumB_const", longint'($signed(b_sum)), 5);
    finish_frame("t6", 2);

    // reset while holding a result
    do_beat(16'd55, 1'b1);
    apply_reset();

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0:       p = 16'h7FFF;
          1:       p = 16'h8000;
          default: p = 16'($urandom);
        endcase
        do_beat(p, 1'(b == len - 1));
      end
      finish_frame("rnd", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
